// File: rtl/charis_defs_pkg.sv
// Shared CHARIS control definitions: opcode map, ALU function codes, immediate
// extension modes, FSM state encoding and the decoder's instruction-class flags.
package charis_defs_pkg;

  localparam int CHARIS_OPC_W  = 6;
  localparam int CHARIS_FUNC_W = 4;

  // CHARIS primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_B     = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_ZEXT     = 2'b00;
  localparam logic [1:0] IMM_SEXT     = 2'b01;
  localparam logic [1:0] IMM_HI16     = 2'b10;
  localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_DEC  = 3'd1,
    S_EXEC = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  typedef struct packed {
    logic is_rtype;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_beq;
    logic is_bne;
    logic is_byte;
    logic illegal;
  } dec_flags_t;

  // True for any instruction that needs the data-memory cycle.
  function automatic logic needs_mem(input dec_flags_t f);
    return f.is_load | f.is_store;
  endfunction

endpackage

// File: rtl/charis_opcode_decode.sv
// Combinational CHARIS opcode classifier: turns the IR opcode into class flags
// plus the ALU function and immediate-extension mode used by the control FSM.
module charis_opcode_decode
  import charis_defs_pkg::*;
#(
  parameter int OPC_W  = CHARIS_OPC_W,
  parameter int FUNC_W = CHARIS_FUNC_W
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] funct,
  output dec_flags_t        flags,
  output logic [FUNC_W-1:0] alu_func,
  output logic [1:0]        imm_ctrl
);

  logic [5:0] opc_s;

  assign opc_s = 6'(opcode);

  // Opcode-to-class mapping; anything not listed is reported as illegal.
  always_comb begin
    flags    = '{default: 1'b0};
    alu_func = FUNC_W'(ALU_ADD);
    imm_ctrl = IMM_ZEXT;
    case (opc_s)
      OP_RTYPE: begin
        flags.is_rtype = 1'b1;
        alu_func       = funct;
      end
      OP_LI, OP_ADDI: begin
        flags.is_imm = 1'b1;
        imm_ctrl     = IMM_SEXT;
      end
      OP_LUI: begin
        flags.is_imm = 1'b1;
        imm_ctrl     = IMM_HI16;
      end
      OP_ANDI: begin
        flags.is_imm = 1'b1;
        alu_func     = FUNC_W'(ALU_AND);
      end
      OP_ORI: begin
        flags.is_imm = 1'b1;
        alu_func     = FUNC_W'(ALU_OR);
      end
      OP_LB: begin
        flags.is_load = 1'b1;
        flags.is_byte = 1'b1;
        imm_ctrl      = IMM_SEXT;
      end
      OP_LW: begin
        flags.is_load = 1'b1;
        imm_ctrl      = IMM_SEXT;
      end
      OP_SB: begin
        flags.is_store = 1'b1;
        flags.is_byte  = 1'b1;
        imm_ctrl       = IMM_SEXT;
      end
      OP_SW: begin
        flags.is_store = 1'b1;
        imm_ctrl       = IMM_SEXT;
      end
      OP_BEQ: begin
        flags.is_branch = 1'b1;
        flags.is_beq    = 1'b1;
        alu_func        = FUNC_W'(ALU_SUB);
        imm_ctrl        = IMM_SEXT_SH2;
      end
      OP_BNE: begin
        flags.is_branch = 1'b1;
        flags.is_bne    = 1'b1;
        alu_func        = FUNC_W'(ALU_SUB);
        imm_ctrl        = IMM_SEXT_SH2;
      end
      OP_B: begin
        flags.is_branch = 1'b1;
        alu_func        = FUNC_W'(ALU_SUB);
        imm_ctrl        = IMM_SEXT_SH2;
      end
      default: begin
        flags.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/charis_control_fsm.sv
// CHARIS multicycle control unit: latches IR in S_IF and sequences datapath enables.
// Build option: define CHARIS_ILLEGAL_TRAP_EN to trap illegal opcodes in S_HALT.
module charis_control_fsm
  import charis_defs_pkg::*;
#(
  parameter int OPC_W  = CHARIS_OPC_W,
  parameter int FUNC_W = CHARIS_FUNC_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              ALU_Zero,
  output logic              PC_Sel,
  output logic              PC_LdEn,
  output logic              RF_WrEn,
  output logic              RF_B_sel,
  output logic              RF_WrData_sel,
  output logic              ALU_Bin_sel,
  output logic [FUNC_W-1:0] ALU_func,
  output logic [1:0]        Imm_Ctrl,
  output logic              MEM_WrEn,
  output logic              ByteOp,
  output logic              Illegal
);

  state_t            state_r;
  logic [31:0]       ir_r;
  dec_flags_t        flags_s;
  logic [FUNC_W-1:0] dec_func_s;
  logic [1:0]        dec_imm_s;
  logic              unused_ir_s;

  logic              pc_sel_r;
  logic              br_eq_r;
  logic              br_ne_r;
  logic              pc_ld_en_r;
  logic              rf_wr_en_r;
  logic              rf_b_sel_r;
  logic              rf_wrdata_sel_r;
  logic              alu_bin_sel_r;
  logic [FUNC_W-1:0] alu_func_r;
  logic [1:0]        imm_ctrl_r;
  logic              mem_wr_en_r;
  logic              byte_op_r;
  logic              illegal_r;

  charis_opcode_decode #(
    .OPC_W  (OPC_W),
    .FUNC_W (FUNC_W)
  ) u_decode (
    .opcode   (ir_r[31 -: OPC_W]),
    .funct    (ir_r[FUNC_W-1:0]),
    .flags    (flags_s),
    .alu_func (dec_func_s),
    .imm_ctrl (dec_imm_s)
  );

  // Register and immediate fields of IR are consumed by the datapath, not here.
  assign unused_ir_s = ^ir_r[31-OPC_W:FUNC_W];

  // State register, IR latch and registered outputs for the state being entered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r         <= S_IF;
      ir_r            <= 32'h0000_0000;
      pc_sel_r        <= 1'b0;
      br_eq_r         <= 1'b0;
      br_ne_r         <= 1'b0;
      pc_ld_en_r      <= 1'b0;
      rf_wr_en_r      <= 1'b0;
      rf_b_sel_r      <= 1'b0;
      rf_wrdata_sel_r <= 1'b0;
      alu_bin_sel_r   <= 1'b0;
      alu_func_r      <= {FUNC_W{1'b0}};
      imm_ctrl_r      <= 2'b00;
      mem_wr_en_r     <= 1'b0;
      byte_op_r       <= 1'b0;
      illegal_r       <= 1'b0;
    end else begin
      pc_sel_r        <= 1'b0;
      br_eq_r         <= 1'b0;
      br_ne_r         <= 1'b0;
      pc_ld_en_r      <= 1'b0;
      rf_wr_en_r      <= 1'b0;
      rf_b_sel_r      <= 1'b0;
      rf_wrdata_sel_r <= 1'b0;
      alu_bin_sel_r   <= 1'b0;
      alu_func_r      <= {FUNC_W{1'b0}};
      imm_ctrl_r      <= 2'b00;
      mem_wr_en_r     <= 1'b0;
      byte_op_r       <= 1'b0;
      illegal_r       <= 1'b0;
      case (state_r)
        S_IF: begin
          ir_r    <= Instr;
          state_r <= S_DEC;
        end
        S_DEC: begin
          if (flags_s.is_branch) begin
            state_r    <= S_BR;
            alu_func_r <= dec_func_s;
            imm_ctrl_r <= dec_imm_s;
            rf_b_sel_r <= 1'b1;
            pc_ld_en_r <= 1'b1;
            pc_sel_r   <= ~(flags_s.is_beq | flags_s.is_bne);
            br_eq_r    <= flags_s.is_beq;
            br_ne_r    <= flags_s.is_bne;
          end else if (flags_s.illegal) begin
`ifdef CHARIS_ILLEGAL_TRAP_EN
            state_r   <= S_HALT;
            illegal_r <= 1'b1;
`else
            // Retire as a NOP: PC+4 without any register write.
            state_r    <= S_WB;
            pc_ld_en_r <= 1'b1;
`endif
          end else begin
            state_r       <= S_EXEC;
            alu_bin_sel_r <= ~flags_s.is_rtype;
            alu_func_r    <= dec_func_s;
            imm_ctrl_r    <= dec_imm_s;
          end
        end
        S_EXEC: begin
          if (needs_mem(flags_s)) begin
            state_r     <= S_MEM;
            byte_op_r   <= flags_s.is_byte;
            mem_wr_en_r <= flags_s.is_store;
            pc_ld_en_r  <= flags_s.is_store;
          end else begin
            state_r    <= S_WB;
            rf_wr_en_r <= flags_s.is_rtype | flags_s.is_imm;
            pc_ld_en_r <= 1'b1;
          end
        end
        S_MEM: begin
          if (flags_s.is_store) begin
            state_r <= S_IF;
          end else begin
            state_r         <= S_WB;
            rf_wr_en_r      <= flags_s.is_load;
            rf_wrdata_sel_r <= 1'b1;
            pc_ld_en_r      <= 1'b1;
          end
        end
        S_WB, S_BR: begin
          state_r <= S_IF;
        end
        S_HALT: begin
`ifdef CHARIS_ILLEGAL_TRAP_EN
          state_r   <= S_HALT;
          illegal_r <= 1'b1;
`else
          state_r <= S_IF;
`endif
        end
        default: begin
          state_r <= S_IF;
        end
      endcase
    end
  end

  // Conditional branches resolve against the zero flag of the S_BR compare.
  assign PC_Sel        = pc_sel_r | (br_eq_r & ALU_Zero) | (br_ne_r & ~ALU_Zero);
  assign PC_LdEn       = pc_ld_en_r;
  assign RF_WrEn       = rf_wr_en_r;
  assign RF_B_sel      = rf_b_sel_r;
  assign RF_WrData_sel = rf_wrdata_sel_r;
  assign ALU_Bin_sel   = alu_bin_sel_r;
  assign ALU_func      = alu_func_r;
  assign Imm_Ctrl      = imm_ctrl_r;
  assign MEM_WrEn      = mem_wr_en_r;
  assign ByteOp        = byte_op_r;
  assign Illegal       = illegal_r;

endmodule
